// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution MAC sequencer.
package conv_pkg;

  localparam int TAPS_DEF   = 9;
  localparam int ADDR_W_DEF = 4;
  localparam int ACC_W_DEF  = 20;
  localparam int PIX_W      = 8;
  localparam int PROD_W     = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/conv_mac_seq_if.sv
// Buffer-read and result-handshake bundle of the MAC sequencer.
// The master modport is the sequencer side; slave is buffers plus consumer.
interface conv_mac_seq_if
  import conv_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
);

  logic                     start;
  logic signed [ACC_W-1:0]  bias;
  logic                     busy;
  logic                     rd_en;
  logic [ADDR_W-1:0]        pix_addr;
  logic [ADDR_W-1:0]        wgt_addr;
  logic signed [PIX_W-1:0]  pix_data;
  logic signed [PIX_W-1:0]  wgt_data;
  logic signed [ACC_W-1:0]  out_data;
  logic                     out_valid;
  logic                     out_ready;

  modport master (
    input  start, bias, pix_data, wgt_data, out_ready,
    output busy, rd_en, pix_addr, wgt_addr, out_data, out_valid
  );

  modport slave (
    output start, bias, pix_data, wgt_data, out_ready,
    input  busy, rd_en, pix_addr, wgt_addr, out_data, out_valid
  );

endinterface

// File: rtl/conv_mac_seq_mul.sv
// Shared 8x8 signed multiplier, purely combinational.
module conv_mac_seq_mul
  import conv_pkg::*;
(
  input  logic signed [PIX_W-1:0]  a,
  input  logic signed [PIX_W-1:0]  b,
  output logic signed [PROD_W-1:0] p
);

  assign p = a * b;

endmodule

// File: rtl/conv_mac_seq.sv
// Sequencer for one convolution output pixel: TAPS reads, shared multiply, bias accumulate.
// Define CONV_RELU_EN to clamp negative results to zero on the output register.
module conv_mac_seq
  import conv_pkg::*;
#(
  parameter int TAPS   = TAPS_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input logic           clk,
  input logic           rst,
  conv_mac_seq_if.master bus
);

  localparam int EXT_W = ACC_W - PROD_W;

  state_t                   state, state_nxt;
  logic [ADDR_W-1:0]        cnt;
  logic                     v0, v1;
  logic signed [PROD_W-1:0] mul_p, prod;
  logic signed [ACC_W-1:0]  acc, res, out_q;
  logic                     out_valid_q;
  logic                     last_issue;
  logic                     drained;

  assign last_issue = (cnt == ADDR_W'(TAPS - 1));
  assign drained    = !v0 && !v1;

  conv_mac_seq_mul u_mul (
    .a (bus.pix_data),
    .b (bus.wgt_data),
    .p (mul_p)
  );

`ifdef CONV_RELU_EN
  assign res = acc[ACC_W-1] ? '0 : acc;
`else
  assign res = acc;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (bus.start)     state_nxt = ISSUE;
      ISSUE: if (last_issue)    state_nxt = DRAIN;
      DRAIN: if (drained)       state_nxt = HOLD;
      HOLD:  if (bus.out_ready) state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // NOTE: state and datapath registers use non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      v0          <= 1'b0;
      v1          <= 1'b0;
      acc         <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      v0 <= (state == ISSUE);
      v1 <= v0;
      if (v1) acc <= acc + {{EXT_W{prod[PROD_W-1]}}, prod};
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            acc <= bias_q();
            cnt <= '0;
          end
        end
        ISSUE: cnt <= last_issue ? '0 : cnt + ADDR_W'(1);
        DRAIN: begin
          if (drained) begin
            out_q       <= res;
            out_valid_q <= 1'b1;
          end
        end
        HOLD: if (bus.out_ready) out_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  // NOTE: the product register carries no reset; v1 qualifies it before it is ever used.
  always_ff @(posedge clk) begin
    prod <= mul_p;
  end

  function automatic logic signed [ACC_W-1:0] bias_q();
    return bus.bias;
  endfunction

  assign bus.busy      = (state != IDLE);
  assign bus.rd_en     = (state == ISSUE);
  assign bus.pix_addr  = cnt;
  assign bus.wgt_addr  = cnt;
  assign bus.out_data  = out_q;
  assign bus.out_valid = out_valid_q;

endmodule
